sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Shares the single SDRAM controller command port between the LCD scan-out reader and the Julia pixel writer. Sits between those two requesters and the controller, and holds the controller idle until initialization completes. Issues one command at a time: either a single-word write or a `BURST_LEN`-word read burst. Returns read data and completion pulses to the requester that owns the command.

## Interface
Parameters:
- `BURST_LEN`, default 8: number of words per read burst. Range 2..255.
- `ADDR_W`, default 22: word address width.

Ports:
- `i_Clk`, in, 1: system clock.
- `i_Reset`, in, 1: reset, synchronous, active-high.
- `i_SDRAM_Initialized`, in, 1: while low, no grants are issued.
- `i_Rd_Req`, in, 1: reader requests a burst. Level signal, held until granted.
- `i_Rd_Address`, in, `ADDR_W`: burst start address.
- `o_Rd_Grant`, out, 1: one-cycle pulse when the read request is accepted.
- `o_Rd_Valid`, out, 1: read word valid.
- `o_Rd_Data`, out, 32: read word.
- `o_Rd_Done`, out, 1: one-cycle pulse, coincident with the last `o_Rd_Valid` of the burst.
- `i_Wr_Req`, in, 1: writer requests a word write. Level signal, held until granted.
- `i_Wr_Address`, in, `ADDR_W`: write address.
- `i_Wr_Data`, in, 32: write data.
- `o_Wr_Grant`, out, 1: one-cycle pulse when the write request is accepted.
- `o_Wr_Done`, out, 1: one-cycle pulse when the controller completes the write.
- `o_Command`, out, 2: controller command. `CMD_IDLE`=0, `CMD_WRITE`=1, `CMD_READ`=2.
- `o_Data_Address`, out, `ADDR_W`: controller address.
- `o_Data_Write`, out, 32: controller write data.
- `i_Data_Write_Done`, in, 1: controller accepted the write word.
- `i_Data_Read_Valid`, in, 1: controller read word valid.
- `i_Data_Read`, in, 32: controller read word.

## Operation
- States:
  - `IDLE`: `o_Command`=`CMD_IDLE`.
  - `WRITE`: `o_Command`=`CMD_WRITE`.
  - `READ`: `o_Command`=`CMD_READ`.
- Decisions are made only in `IDLE`, and only when `i_SDRAM_Initialized`=1.
- Arbitration without the macro: fixed priority, read over write.
- Read accept in `IDLE`:
  - Latch `i_Rd_Address` into `o_Data_Address`.
  - Pulse `o_Rd_Grant`.
  - Load word counter with `BURST_LEN`.
  - Go to `READ`.
- Write accept in `IDLE`:
  - Latch `i_Wr_Address` and `i_Wr_Data` into `o_Data_Address` and `o_Data_Write`.
  - Pulse `o_Wr_Grant`.
  - Go to `WRITE`.
  - After the grant the requester may change its address/data or drop the request.
- `WRITE`:
  - On `i_Data_Write_Done`: pulse `o_Wr_Done` and go to `IDLE`.
  - Otherwise hold the command, address and data stable.
- `READ`:
  - Each `i_Data_Read_Valid` decrements the counter and forwards the word.
  - On the last word, pulse `o_Rd_Done` and go to `IDLE`.
- At least one `CMD_IDLE` cycle always separates consecutive commands.
- The word counter is `$clog2(BURST_LEN+1)` bits wide. There is no address arithmetic: the controller increments addresses internally.
- Spurious inputs are ignored:
  - `i_Data_Write_Done` outside `WRITE`.
  - `i_Data_Read_Valid` outside `READ`, including any beyond the counted words.
- `i_SDRAM_Initialized` falling during a command: the command completes normally, then no new grants are issued.

## Timing
- Reset values, set by `i_Reset` at the next edge:
  - State `IDLE`.
  - `o_Command`=0, `o_Data_Address`=0, `o_Data_Write`=0.
  - All grant, valid and done outputs 0; `o_Rd_Data`=0; counter 0.
- Reset mid-command: `o_Command`=`CMD_IDLE` on the next edge, and no `Done` pulse is issued.
- Request to command: a request seen in `IDLE` at edge N gives `o_Command` and grant high from edge N+1 (both registered).
- Read data: `o_Rd_Valid` and `o_Rd_Data` are `i_Data_Read_Valid` and `i_Data_Read` registered, one cycle of latency.
  - `o_Rd_Done` aligns with the final `o_Rd_Valid`.
  - The state returns to `IDLE` on the same edge that registers the final word.
- Write completion: `o_Wr_Done` is registered, one cycle after `i_Data_Write_Done`. `o_Command` is `CMD_IDLE` on that same edge.
- Simultaneous `i_Rd_Req` and `i_Wr_Req` in `IDLE`: one grant only, chosen by the arbitration rule.
- Grants never occur in back-to-back cycles.

## Configuration
- `SDRAM_ARB_ROUND_ROBIN_EN` defined:
  - A one-bit last-owner flag selects the winner.
  - When both requests are pending, the requester other than the last owner wins.
  - The flag resets to "write", so the first contested grant goes to read.
  - The flag updates on every grant.
- Not defined: fixed read priority. A continuously asserted `i_Rd_Req` starves the writer.

## Test plan
- Held in reset, then `i_Reset` released with `i_SDRAM_Initialized`=0 and both requests high -> `o_Command` stays 0 and no grants appear for 20 cycles.
- `i_SDRAM_Initialized`=1, write of 0x0001F4 with data 0xA5A5A5A5 -> `o_Wr_Grant` pulse, then `o_Command`=1 with that address and data. `i_Data_Write_Done` after 3 cycles -> `o_Wr_Done` one cycle later and `o_Command`=0.
- Read burst at 0x000100 with `BURST_LEN`=8 and valid words 0..7 with gaps -> eight `o_Rd_Valid`, data in order, `o_Rd_Done` with word 7. A ninth `i_Data_Read_Valid` produces no output.
- Both requests asserted continuously:
  - Without the macro: only read grants.
  - With the macro: grants alternate R,W,R,W, with a `CMD_IDLE` cycle between commands.
- `i_Reset` asserted after word 3 of a burst -> `o_Command`=0 next edge, no `o_Rd_Done`, and the next request behaves normally.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller command port between the LCD
// scan-out reader (BURST_LEN-word read bursts) and the Julia pixel writer
// (single-word writes). One command at a time, always separated by at least
// one CMD_IDLE cycle. Nothing is granted until the SDRAM reports it is
// initialized.
//
// Optional feature: define SDRAM_ARB_ROUND_ROBIN_EN to alternate ownership
// between reader and writer when both are requesting. Without it, read has
// fixed priority over write.
module sdram_arbiter #(
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 22
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_SDRAM_Initialized,
  input  logic              i_Rd_Req,
  input  logic [ADDR_W-1:0] i_Rd_Address,
  output logic              o_Rd_Grant,
  output logic              o_Rd_Valid,
  output logic [31:0]       o_Rd_Data,
  output logic              o_Rd_Done,
  input  logic              i_Wr_Req,
  input  logic [ADDR_W-1:0] i_Wr_Address,
  input  logic [31:0]       i_Wr_Data,
  output logic              o_Wr_Grant,
  output logic              o_Wr_Done,
  output logic [1:0]        o_Command,
  output logic [ADDR_W-1:0] o_Data_Address,
  output logic [31:0]       o_Data_Write,
  input  logic              i_Data_Write_Done,
  input  logic              i_Data_Read_Valid,
  input  logic [31:0]       i_Data_Read
);

  // State encoding equals the controller command, so o_Command is the state
  // register itself and is therefore registered.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;

  localparam int              CNT_W      = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] BURST_LOAD = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(1);

  logic [1:0]        state_reg, state_next;
  logic [CNT_W-1:0]  count_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rd_data_reg;
  logic              rd_grant_reg, wr_grant_reg;
  logic              rd_valid_reg, rd_done_reg, wr_done_reg;

  logic pick_rd, pick_wr;
  logic accept_rd, accept_wr;
  logic in_idle, in_write, in_read;
  logic read_word, read_last, write_fin;

  assign in_idle  = (state_reg == ST_IDLE);
  assign in_write = (state_reg == ST_WRITE);
  assign in_read  = (state_reg == ST_READ);

  // Only words arriving while a burst is owned count; extras are dropped.
  assign read_word = in_read && i_Data_Read_Valid;
  assign read_last = read_word && (count_reg == LAST_WORD);
  assign write_fin = in_write && i_Data_Write_Done;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  // Last-owner flag: 1 = reader owned the previous command. Resets to the
  // writer so the first contested grant goes to the reader.
  logic last_rd_reg;

  // Winner selection: the requester that did not own last time wins a tie.
  always_comb begin
    pick_rd = i_Rd_Req && (!i_Wr_Req || !last_rd_reg);
    pick_wr = i_Wr_Req && !pick_rd;
  end
`else
  // Winner selection: fixed read priority (a held read request starves writes).
  always_comb begin
    pick_rd = i_Rd_Req;
    pick_wr = i_Wr_Req && !pick_rd;
  end
`endif

  assign accept_rd = in_idle && i_SDRAM_Initialized && pick_rd;
  assign accept_wr = in_idle && i_SDRAM_Initialized && pick_wr;

  // Next-state logic: decisions only in IDLE; commands always return to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept_rd)      state_next = ST_READ;
        else if (accept_wr) state_next = ST_WRITE;
      end
      ST_WRITE: if (write_fin) state_next = ST_IDLE;
      ST_READ:  if (read_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State, command operands, word counter and registered requester outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rd_data_reg  <= '0;
      rd_grant_reg <= 1'b0;
      wr_grant_reg <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_done_reg  <= 1'b0;
      wr_done_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rd_grant_reg <= accept_rd;
      wr_grant_reg <= accept_wr;
      rd_valid_reg <= read_word;
      rd_done_reg  <= read_last;
      wr_done_reg  <= write_fin;

      if (accept_rd) begin
        addr_reg  <= i_Rd_Address;
        count_reg <= BURST_LOAD;
      end else if (accept_wr) begin
        addr_reg  <= i_Wr_Address;
        wdata_reg <= i_Wr_Data;
      end

      if (read_word) begin
        rd_data_reg <= i_Data_Read;
        count_reg   <= count_reg - LAST_WORD;
      end
    end
  end

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  // Remember who owned the most recent grant.
  always_ff @(posedge i_Clk) begin
    if (i_Reset)                     last_rd_reg <= 1'b0;
    else if (accept_rd || accept_wr) last_rd_reg <= accept_rd;
  end
`endif

  assign o_Command      = state_reg;
  assign o_Data_Address = addr_reg;
  assign o_Data_Write   = wdata_reg;
  assign o_Rd_Grant     = rd_grant_reg;
  assign o_Wr_Grant     = wr_grant_reg;
  assign o_Rd_Valid     = rd_valid_reg;
  assign o_Rd_Data      = rd_data_reg;
  assign o_Rd_Done      = rd_done_reg;
  assign o_Wr_Done      = wr_done_reg;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Testbench for sdram_arbiter: directed vectors, a transaction-level model
// compared against the DUT every cycle, and literal expectations per scenario.
module tb_sdram_arbiter;

  localparam int BURST_LEN = 8;
  localparam int ADDR_W    = 22;

  logic              clk = 1'b0;
  logic              i_Reset = 1'b1;
  logic              i_SDRAM_Initialized = 1'b0;
  logic              i_Rd_Req = 1'b0;
  logic [ADDR_W-1:0] i_Rd_Address = '0;
  logic              o_Rd_Grant, o_Rd_Valid, o_Rd_Done;
  logic [31:0]       o_Rd_Data;
  logic              i_Wr_Req = 1'b0;
  logic [ADDR_W-1:0] i_Wr_Address = '0;
  logic [31:0]       i_Wr_Data = '0;
  logic              o_Wr_Grant, o_Wr_Done;
  logic [1:0]        o_Command;
  logic [ADDR_W-1:0] o_Data_Address;
  logic [31:0]       o_Data_Write;
  logic              i_Data_Write_Done = 1'b0;
  logic              i_Data_Read_Valid = 1'b0;
  logic [31:0]       i_Data_Read = '0;

  sdram_arbiter #(.BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W)) dut (
    .i_Clk(clk), .i_Reset(i_Reset), .i_SDRAM_Initialized(i_SDRAM_Initialized),
    .i_Rd_Req(i_Rd_Req), .i_Rd_Address(i_Rd_Address), .o_Rd_Grant(o_Rd_Grant),
    .o_Rd_Valid(o_Rd_Valid), .o_Rd_Data(o_Rd_Data), .o_Rd_Done(o_Rd_Done),
    .i_Wr_Req(i_Wr_Req), .i_Wr_Address(i_Wr_Address), .i_Wr_Data(i_Wr_Data),
    .o_Wr_Grant(o_Wr_Grant), .o_Wr_Done(o_Wr_Done), .o_Command(o_Command),
    .o_Data_Address(o_Data_Address), .o_Data_Write(o_Data_Write),
    .i_Data_Write_Done(i_Data_Write_Done), .i_Data_Read_Valid(i_Data_Read_Valid),
    .i_Data_Read(i_Data_Read)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_passed = 0;

  // ---------------------------------------------------------------- model
  // Tracks who owns the controller and how many burst words remain, and
  // derives every output from the arbitration rules.
  int                owner = 0;       // 0 none, 1 writer, 2 reader
  int                words_left = 0;
  bit                last_was_rd = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [31:0]       m_wdata = '0, m_rd_data = '0;
  bit m_rd_grant, m_wr_grant, m_rd_valid, m_rd_done, m_wr_done;

  function automatic bit reader_wins();
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    return i_Rd_Req && (!i_Wr_Req || !last_was_rd);
`else
    return i_Rd_Req;
`endif
  endfunction

  always @(posedge clk) begin
    bit rd_wins;
    rd_wins = reader_wins();
    m_rd_grant <= 1'b0; m_wr_grant <= 1'b0; m_rd_valid <= 1'b0;
    m_rd_done  <= 1'b0; m_wr_done  <= 1'b0;
    if (i_Reset) begin
      owner <= 0; words_left <= 0; last_was_rd <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_rd_data <= '0;
    end else if (owner == 2) begin
      if (i_Data_Read_Valid) begin
        m_rd_valid <= 1'b1;
        m_rd_data  <= i_Data_Read;
        words_left <= words_left - 1;
        if (words_left == 1) begin m_rd_done <= 1'b1; owner <= 0; end
      end
    end else if (owner == 1) begin
      if (i_Data_Write_Done) begin m_wr_done <= 1'b1; owner <= 0; end
    end else if (i_SDRAM_Initialized && (i_Rd_Req || i_Wr_Req)) begin
      last_was_rd <= rd_wins;
      if (rd_wins) begin
        owner <= 2; words_left <= BURST_LEN; m_addr <= i_Rd_Address; m_rd_grant <= 1'b1;
      end else begin
        owner <= 1; m_addr <= i_Wr_Address; m_wdata <= i_Wr_Data; m_wr_grant <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------- per-cycle compare
  bit cmp_en = 1'b0;
  bit prev_grant = 1'b0;
  always @(negedge clk) begin
    bit ok, btb;
    if (cmp_en) begin
      btb = prev_grant && (o_Rd_Grant || o_Wr_Grant);
      ok = (o_Command == 2'(owner)) && (o_Data_Address == m_addr) &&
           (o_Data_Write == m_wdata) && (o_Rd_Grant == m_rd_grant) &&
           (o_Wr_Grant == m_wr_grant) && (o_Rd_Valid == m_rd_valid) &&
           (o_Rd_Data == m_rd_data) && (o_Rd_Done == m_rd_done) &&
           (o_Wr_Done == m_wr_done) && !btb;
      n_checks++;
      if (ok) n_passed++;
      else $display("FAIL cycle t=%0t got cmd=%0d addr=%0h wd=%0h rg=%0b wg=%0b rv=%0b rd=%0h rdn=%0b wdn=%0b btb=%0b expected cmd=%0d addr=%0h wd=%0h rg=%0b wg=%0b rv=%0b rd=%0h rdn=%0b wdn=%0b",
                    $time, o_Command, o_Data_Address, o_Data_Write, o_Rd_Grant, o_Wr_Grant,
                    o_Rd_Valid, o_Rd_Data, o_Rd_Done, o_Wr_Done, btb, owner, m_addr, m_wdata,
                    m_rd_grant, m_wr_grant, m_rd_valid, m_rd_data, m_rd_done, m_wr_done);
      prev_grant = o_Rd_Grant || o_Wr_Grant;
    end
  end

  // Collect returned read words and the word index each done lands on.
  logic [31:0] rd_words[$];
  int          done_idx[$];
  always @(negedge clk) begin
    if (o_Rd_Valid) rd_words.push_back(o_Rd_Data);
    if (o_Rd_Done)  begin
      done_idx.push_back(rd_words.size() - 1);
      $display("read done  addr=%06h words=%0d", o_Data_Address, rd_words.size());
    end
    if (o_Rd_Grant) $display("read grant addr=%06h", o_Data_Address);
    if (o_Wr_Grant) $display("write grant addr=%06h data=%08h", o_Data_Address, o_Data_Write);
    if (o_Wr_Done)  $display("write done addr=%06h", o_Data_Address);
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_grant(output bit is_rd);
    bit got = 1'b0;
    is_rd = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      tick();
      if (o_Rd_Grant || o_Wr_Grant) begin got = 1'b1; is_rd = o_Rd_Grant; end
    end
    if (!got) check("grant_timeout", 64'd0, 64'd1);
  endtask

  task automatic feed_words(input int n, input logic [31:0] base, input int gap_mod);
    for (int i = 0; i < n; i++) begin
      i_Data_Read_Valid = 1'b1; i_Data_Read = base + 32'(i);
      tick();
      i_Data_Read_Valid = 1'b0;
      for (int g = 0; g < (gap_mod == 0 ? 0 : i % gap_mod); g++) tick();
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    bit is_rd, seen_grant, cmd_busy;
    int base, dbase;
    bit exp_rd[4];

    // Reset held with both requests high, controller not initialized.
    i_Rd_Req = 1'b1; i_Wr_Req = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick(); tick();
    check("reset_cmd", 64'(o_Command), 64'd0);
    check("reset_addr", 64'(o_Data_Address), 64'd0);
    check("reset_outs", {60'd0, o_Rd_Grant, o_Wr_Grant, o_Rd_Valid, o_Wr_Done}, 64'd0);
    i_Reset = 1'b0;
    seen_grant = 1'b0; cmd_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen_grant |= o_Rd_Grant | o_Wr_Grant;
      cmd_busy   |= (o_Command != 2'd0);
    end
    check("uninit_no_grant", 64'(seen_grant), 64'd0);
    check("uninit_cmd_idle", 64'(cmd_busy), 64'd0);

    // Single write; requester changes inputs right after the grant.
    i_Rd_Req = 1'b0; i_Wr_Req = 1'b1; i_SDRAM_Initialized = 1'b1;
    i_Wr_Address = 22'h0001F4; i_Wr_Data = 32'hA5A5A5A5;
    wait_grant(is_rd);
    check("wr_grant", 64'(o_Wr_Grant), 64'd1);
    check("wr_cmd", 64'(o_Command), 64'd1);
    check("wr_addr", 64'(o_Data_Address), 64'h1F4);
    check("wr_data", 64'(o_Data_Write), 64'hA5A5A5A5);
    i_Wr_Req = 1'b0; i_Wr_Address = 22'h3FFFFF; i_Wr_Data = 32'h0;
    tick(); tick(); tick();
    check("wr_hold", {30'd0, o_Command, o_Data_Write}, {30'd0, 2'd1, 32'hA5A5A5A5});
    i_Data_Write_Done = 1'b1;
    tick();
    i_Data_Write_Done = 1'b0;
    check("wr_done", 64'(o_Wr_Done), 64'd1);
    check("wr_done_cmd", 64'(o_Command), 64'd0);
    i_Data_Write_Done = 1'b1;          // spurious, must be ignored in IDLE
    tick(); tick();
    i_Data_Write_Done = 1'b0;
    check("wr_spurious", 64'(o_Wr_Done), 64'd0);

    // Read burst with gaps, followed by a stray ninth word.
    i_Rd_Req = 1'b1; i_Rd_Address = 22'h000100;
    base = rd_words.size(); dbase = done_idx.size();
    wait_grant(is_rd);
    check("rd_grant", 64'(o_Rd_Grant), 64'd1);
    check("rd_cmd_addr", {o_Command, 40'd0, o_Data_Address}, {2'd2, 40'd0, 22'h100});
    i_Rd_Req = 1'b0; i_Rd_Address = '0;
    feed_words(8, 32'hD0000000, 3);
    tick();
    check("rd_cmd_after", 64'(o_Command), 64'd0);
    i_Data_Read_Valid = 1'b1; i_Data_Read = 32'hDEADBEEF;
    tick();
    i_Data_Read_Valid = 1'b0;
    tick();
    check("rd_count", 64'(rd_words.size() - base), 64'd8);
    for (int k = 0; k < 8 && base + k < rd_words.size(); k++)
      check($sformatf("rd_word%0d", k), 64'(rd_words[base + k]), 64'hD0000000 + 64'(k));
    check("rd_done_count", 64'(done_idx.size() - dbase), 64'd1);
    if (done_idx.size() > dbase) check("rd_done_pos", 64'(done_idx[dbase]), 64'(base + 7));

    // Both requests held continuously.
    i_Reset = 1'b1; tick(); tick(); i_Reset = 1'b0;
    i_Rd_Req = 1'b1; i_Wr_Req = 1'b1; i_Rd_Address = 22'h000400; i_Wr_Address = 22'h000800;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    exp_rd = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_rd = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int g = 0; g < 4; g++) begin
      wait_grant(is_rd);
      check($sformatf("contest_owner%0d", g), 64'(is_rd), 64'(exp_rd[g]));
      if (is_rd) feed_words(BURST_LEN, 32'h11110000 + 32'(g << 8), 0);
      else begin i_Data_Write_Done = 1'b1; tick(); i_Data_Write_Done = 1'b0; end
    end
    i_Rd_Req = 1'b0; i_Wr_Req = 1'b0;
    tick(); tick();

    // Reset in the middle of a burst, then a normal burst.
    i_Rd_Req = 1'b1; i_Rd_Address = 22'h000300;
    wait_grant(is_rd);
    i_Rd_Req = 1'b0;
    dbase = done_idx.size();
    feed_words(4, 32'hC0000000, 0);
    i_Reset = 1'b1;
    tick();
    check("rst_mid_cmd", 64'(o_Command), 64'd0);
    check("rst_mid_done", 64'(o_Rd_Done), 64'd0);
    i_Reset = 1'b0;
    tick(); tick();
    check("rst_no_done", 64'(done_idx.size() - dbase), 64'd0);
    i_Rd_Req = 1'b1; i_Rd_Address = 22'h000200;
    base = rd_words.size();
    wait_grant(is_rd);
    check("rd2_grant_addr", {o_Rd_Grant, 41'd0, o_Data_Address}, {1'b1, 41'd0, 22'h200});
    i_Rd_Req = 1'b0;
    feed_words(8, 32'hE0000000, 2);
    tick();
    check("rd2_done_count", 64'(done_idx.size() - dbase), 64'd1);
    if (done_idx.size() > dbase) check("rd2_done_pos", 64'(done_idx[dbase]), 64'(base + 7));
    check("rd2_last_word", 64'(rd_words[rd_words.size() - 1]), 64'hE0000007);

    tick();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
